// File: rtl/dice_i2c_pkg.sv
// dice_i2c_pkg: shared state encoding and constants for the dice I2C target
package dice_i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE
   } state_t;
   localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h70;
   localparam logic       RW_READ          = 1'b1;
endpackage

// File: rtl/dice_i2c_target_filter.sv
// i2c_line_filter: 2-FF synchroniser plus stability filter for one I2C line
//   clk, rst  : system clock, synchronous active-high reset
//   din       : raw asynchronous pin
//   level     : filtered level (presets to 1, bus idle)
//   rise/fall : one-clk pulses on the same clk the filtered level changes
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          diff, hit;
   // a new level is accepted on its FILTER_LEN-th consecutive differing sample
   assign diff = sync[1] != level;
   assign hit  = diff && (cnt == CW'(FILTER_LEN - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync  <= {sync[0], din};
         cnt   <= (diff && !hit) ? cnt + 1'b1 : '0;
         level <= hit ? sync[1] : level;
         rise  <= hit & sync[1];
         fall  <= hit & ~sync[1];
      end
   end
endmodule

// File: rtl/dice_i2c_target.sv
// dice_i2c_target: I2C target producing a register-write stream (optional reads via DICE_I2C_READ_EN)
//   clk, rst          : system clock, synchronous active-high reset
//   scl_in, sda_in    : raw bus pins; sda_oe=1 pulls SDA low (open drain)
//   wr_valid/addr/data: one-clk write pulse with sub-address and byte
//   rd_addr, rd_data  : sub-address being read and its combinational data (read build only)
//   busy              : high from an accepted START until the next STOP
import dice_i2c_pkg::*;
module dice_i2c_target #(
   parameter logic [6:0] I2C_ADDR   = DEFAULT_I2C_ADDR,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);
   state_t     state, state_n;
   logic [7:0] sh, sh_n, sub_addr, sub_n, wa_n, wd_n;
   logic [2:0] cnt, cnt_n;
   logic       smp, smp_n, oe_n, wv_n, busy_n;
   logic       scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
   logic       start, stop, done, addr_hit;
`ifdef DICE_I2C_READ_EN
   localparam logic READ_OK = 1'b1;
   logic [7:0] tx, tx_n;
   assign rd_addr = sub_addr;
`else
   localparam logic READ_OK = 1'b0;
   logic unused_rd;
   assign unused_rd = ^rd_data;
   assign rd_addr   = 8'h00;
`endif
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (.clk(clk), .rst(rst), .din(scl_in), .level(scl_f), .rise(scl_rise), .fall(scl_fall));
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (.clk(clk), .rst(rst), .din(sda_in), .level(sda_f), .rise(sda_rise), .fall(sda_fall));
   assign start    = sda_fall & scl_f;
   assign stop     = sda_rise & scl_f;
   assign done     = cnt == 3'd7;
   assign addr_hit = (sh[7:1] == I2C_ADDR) && (sh[0] != RW_READ || READ_OK);
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sh       <= '0;
         cnt      <= '0;
         smp      <= 1'b0;
         sub_addr <= '0;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
`ifdef DICE_I2C_READ_EN
         tx       <= '0;
`endif
      end else begin
         state    <= state_n;
         sh       <= sh_n;
         cnt      <= cnt_n;
         smp      <= smp_n;
         sub_addr <= sub_n;
         sda_oe   <= oe_n;
         wr_valid <= wv_n;
         wr_addr  <= wa_n;
         wr_data  <= wd_n;
         busy     <= busy_n;
`ifdef DICE_I2C_READ_EN
         tx       <= tx_n;
`endif
      end
   end
   // smp marks that an SCL high phase was seen, so the first fall after START is not a bit
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      smp_n   = smp;
      sub_n   = sub_addr;
      oe_n    = sda_oe;
      wv_n    = 1'b0;
      wa_n    = wr_addr;
      wd_n    = wr_data;
      busy_n  = busy;
`ifdef DICE_I2C_READ_EN
      tx_n    = tx;
`endif
      if (start) begin
         state_n = ADDR;
         cnt_n   = '0;
         smp_n   = 1'b0;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
      end else if (stop) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (state != IDLE && scl_rise) begin
         smp_n = 1'b1;
         if (state inside {ADDR, SUB, WDATA, RDATA_MACK}) sh_n = {sh[6:0], sda_f};
`ifdef DICE_I2C_READ_EN
         // increment before the falling edge so rd_data already reflects the next address
         if (state == RDATA_MACK && !sda_f) sub_n = sub_addr + 8'd1;
`endif
      end else if (state != IDLE && scl_fall && smp) begin
         smp_n = 1'b0;
         if (state inside {ADDR, SUB, WDATA, RDATA}) cnt_n = cnt + 3'd1;
         case (state)
            ADDR: if (done) begin
               state_n = addr_hit ? ADDR_ACK : IGNORE;
               oe_n    = addr_hit;
            end
            ADDR_ACK: begin
               state_n = SUB;
               oe_n    = 1'b0;
`ifdef DICE_I2C_READ_EN
               if (sh[0] == RW_READ) begin
                  state_n = RDATA;
                  tx_n    = rd_data;
                  oe_n    = ~rd_data[7];
               end
`endif
            end
            SUB: if (done) begin
               state_n = SUB_ACK;
               sub_n   = sh;
               oe_n    = 1'b1;
            end
            SUB_ACK, WDATA_ACK: begin
               state_n = WDATA;
               oe_n    = 1'b0;
            end
            WDATA: if (done) begin
               state_n = WDATA_ACK;
               wv_n    = 1'b1;
               wa_n    = sub_addr;
               wd_n    = sh;
               sub_n   = sub_addr + 8'd1;
               oe_n    = 1'b1;
            end
`ifdef DICE_I2C_READ_EN
            RDATA: begin
               state_n = done ? RDATA_MACK : RDATA;
               tx_n    = {tx[6:0], 1'b0};
               oe_n    = done ? 1'b0 : ~tx[6];
            end
            RDATA_MACK: begin
               state_n = sh[0] ? IGNORE : RDATA;
               tx_n    = rd_data;
               oe_n    = sh[0] ? 1'b0 : ~rd_data[7];
            end
`endif
            default: ;
         endcase
      end
   end
endmodule
